fe_bf16_unscr: RTL and testbench
================================

Name: fe_bf16_unscr

Overview:
- Downstream stage of the 16-point parallel FFT engine (radix-4 x radix-4).
- Captures each 16-bin complex frame the engine produces in digit-reversed lane order.
- Reorders the bins to natural frequency order, holds them in a two-frame buffer and streams them out NLANE bins per cycle with a valid/ready handshake.
- The FFT engine has no backpressure, so a frame that arrives while both buffers are full is dropped and flagged.

Parameters:
- NBW, 12, width of each I/Q component, signed (matches the FFT output width)
- NLANE, 4, bins emitted per output beat; legal values 1, 2, 4, 8, 16
- NBEAT, 16/NLANE, derived localparam: beats per frame

Ports:
- clk  in  1  clock
- rst_async_n  in  1  asynchronous reset, active-low
- i_valid  in  1  frame strobe; valid already delayed by the integrator to align with the FFT output
- i_data  in  [15:0][1:0] x NBW signed  FFT output; lane p, component 0 = I, 1 = Q
- o_valid  out  1  output beat valid
- i_ready  in  1  consumer ready
- o_data  out  [NLANE-1:0][1:0] x NBW signed  bins in natural order; lane m of beat t = bin t*NLANE+m
- o_sof  out  1  high on beat 0 of a frame
- o_eof  out  1  high on beat NBEAT-1
- o_ovf  out  1  sticky overflow: a frame was dropped
- i_clr_ovf  in  1  synchronous clear of o_ovf
- o_level  out  2  frames currently buffered (0..2)

Behaviour:
- Reorder rule: input lane p holds bin b = (p mod 4)*4 + (p div 4). Reordering is applied at write time, so each buffer stores bins in natural order.
- Buffer: two frame slots (ping/pong), 1-bit write pointer wp, 1-bit read pointer rp, level counter 0..2, beat counter 0..NBEAT-1.
- Write: on i_valid with level<2, the reordered frame is written to slot wp, wp toggles and level increments. All 16 bins are captured in one cycle.
- Drop: on i_valid with level==2 the frame is discarded, o_ovf is set and stays set until i_clr_ovf. If set and clear occur in the same cycle, set wins.
- Read: o_valid = (level>0). o_data = slot rp, bins beat*NLANE .. beat*NLANE+NLANE-1.
- A transfer occurs when o_valid and i_ready are both high. On a transfer the beat counter increments. On the transfer with beat==NBEAT-1 the beat counter wraps to 0, rp toggles and level decrements.
- Output stability: while o_valid=1 and i_ready=0, o_data, o_sof and o_eof hold their values.
- Simultaneous write and last-beat read in one cycle: level is unchanged, both pointers toggle. With level==2 this write is accepted, not dropped, because the slot frees in the same cycle.
- Latency: a frame with i_valid at cycle n gives o_valid=1 at cycle n+1 when level was 0.
- Throughput: one frame per cycle when NLANE=16. Otherwise sustainable i_valid spacing is >= NBEAT cycles with i_ready held high.
- o_data is driven combinationally from the registered slot (mux by rp/beat); no additional pipeline register.
- Reset values: o_valid=0, o_sof=0, o_eof=0, o_ovf=0, o_level=0, all pointers and counters 0. Buffer contents are not reset; o_data is don't-care while o_valid=0.
- Reset mid-frame: the partially read frame and any buffered frame are discarded. After reset the first new i_valid starts at beat 0.
- No arithmetic: widths pass through unchanged.

Decomposition:
- Package fe_pkg holds:
  - constants NS=16, I=0, Q=1
  - a function digit_rev16(p) that returns the bin index; used by RTL and bench
  - typedef cplx_t for a NBW-wide I/Q pair, parameterised via the module
- One sub-module, fe_frame_buf2: the two-slot frame store with wp/rp/level and drop/ovf logic.
- The top holds the reorder network, beat counter, sof/eof and the output mux.

Test Plan:
- Single frame, NLANE=4, i_ready=1, lane p I=p, Q=-p: expect 4 beats starting the cycle after i_valid, beat0 I = {0,4,8,12}, beat1 I = {1,5,9,13}; o_sof on beat 0, o_eof on beat 3, o_level back to 0.
- Backpressure: i_ready toggles 1,0,0,1 during a frame: o_data is stable across stalled cycles, no beat is lost or duplicated, and the beat order matches digit_rev16.
- Overflow: three frames A, B, C on consecutive cycles with i_ready=0: A and B are buffered (o_level=2), C is dropped, o_ovf=1. After i_ready=1, A then B are output, C never appears. i_clr_ovf clears o_ovf.
- Simultaneous: level=2, i_valid coincides with the last-beat transfer of frame A: the new frame is accepted, o_ovf stays 0, level stays 2.
- NLANE=16 streaming: i_valid every cycle with i_ready=1: one full natural-order frame per cycle, o_sof=o_eof=1 on every beat, o_level never exceeds 1.
- Reset mid-operation: assert rst_async_n low during beat 2 of a buffered frame: all outputs go to 0 immediately. After release, a new frame is output from beat 0 with no old data.

Source files
------------

// File: rtl/fe_pkg.sv
// Shared constants and the radix-4 x radix-4 digit-reversal map for the
// 16-point FFT unscrambler.
package fe_pkg;

  localparam int NS = 16;
  localparam int I  = 0;
  localparam int Q  = 1;

  // Lane p carries bin (p mod 4)*4 + (p div 4): the two base-4 digits swap.
  function automatic logic [3:0] digit_rev16(input logic [3:0] p);
    return {p[1:0], p[3:2]};
  endfunction

endpackage

// File: rtl/fe_bf16_unscr_if.sv
// Frame-in / beat-out bundle of the FFT unscrambler. The slave modport is the
// unscrambler; the master modport is the FFT engine plus the downstream consumer.
interface fe_bf16_unscr_if #(
  parameter int NBW   = 12,
  parameter int NLANE = 4
);

  logic                                  i_valid;
  logic signed [15:0][1:0][NBW-1:0]      i_data;
  logic                                  i_ready;
  logic                                  o_valid;
  logic signed [NLANE-1:0][1:0][NBW-1:0] o_data;
  logic                                  o_sof;
  logic                                  o_eof;

  modport master (
    output i_valid, i_data, i_ready,
    input  o_valid, o_data, o_sof, o_eof
  );

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_valid, o_data, o_sof, o_eof
  );

endinterface

// File: rtl/fe_frame_buf2.sv
// Two-slot (ping/pong) whole-frame store with occupancy tracking. A frame that
// arrives while both slots are held is dropped and latched into a sticky flag.
module fe_frame_buf2
  import fe_pkg::*;
#(
  parameter int NBW = 12
) (
  input  logic                         clk,
  input  logic                         rst_async_n,
  input  logic                         wr_en,
  input  logic [NS-1:0][1:0][NBW-1:0]  wr_frame,
  input  logic                         rd_done,
  input  logic                         clr_ovf,
  output logic [NS-1:0][1:0][NBW-1:0]  rd_frame,
  output logic [1:0]                   level,
  output logic                         ovf
);

  logic [NS-1:0][1:0][NBW-1:0] slot_p0 [2];
  logic       wp;
  logic       rp;
  logic       wr_acc;
  logic       drop;
  logic [1:0] level_nxt;

  // A full buffer still accepts a frame when the read side frees a slot this cycle.
  assign wr_acc = wr_en && ((level != 2'd2) || rd_done);
  assign drop   = wr_en && !wr_acc;

  always_comb begin
    level_nxt = level;
    unique case ({wr_acc, rd_done})
      2'b10:   level_nxt = level + 2'd1;
      2'b01:   level_nxt = level - 2'd1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      level <= 2'd0;
      ovf   <= 1'b0;
    end else begin
      if (wr_acc)
        wp <= ~wp;
      if (rd_done)
        rp <= ~rp;
      level <= level_nxt;
      if (drop)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

  // Frame storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (wr_acc)
      slot_p0[wp] <= wr_frame;
  end

  assign rd_frame = slot_p0[rp];

endmodule

// File: rtl/fe_bf16_unscr.sv
// FFT output unscrambler: digit-reverses a 16-bin frame into natural order,
// buffers up to two frames and streams them out NLANE bins per beat.
module fe_bf16_unscr
  import fe_pkg::*;
#(
  parameter int NBW   = 12,
  parameter int NLANE = 4
) (
  input  logic            clk,
  input  logic            rst_async_n,
  fe_bf16_unscr_if.slave  bus,
  input  logic            i_clr_ovf,
  output logic            o_ovf,
  output logic [1:0]      o_level
);

  localparam int NBEAT = NS / NLANE;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  typedef logic signed [1:0][NBW-1:0] cplx_t;
  typedef cplx_t [NS-1:0] frame_t;

  frame_t        wr_frame;
  frame_t        rd_frame;
  logic [BW-1:0] beat;
  logic          last_beat;
  logic          xfer;
  logic          rd_done;
  logic [3:0]    base;

  // Reorder at write time so both slots hold bins in natural order.
  always_comb begin
    wr_frame = '0;
    for (int p = 0; p < NS; p++) begin
      wr_frame[digit_rev16(4'(p))][I] = bus.i_data[p][I];
      wr_frame[digit_rev16(4'(p))][Q] = bus.i_data[p][Q];
    end
  end

  fe_frame_buf2 #(
    .NBW (NBW)
  ) u_buf (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .wr_en       (bus.i_valid),
    .wr_frame    (wr_frame),
    .rd_done     (rd_done),
    .clr_ovf     (i_clr_ovf),
    .rd_frame    (rd_frame),
    .level       (o_level),
    .ovf         (o_ovf)
  );

  assign bus.o_valid = (o_level != 2'd0);
  assign last_beat   = (beat == BW'(NBEAT - 1));
  assign xfer        = bus.o_valid && bus.i_ready;
  assign rd_done     = xfer && last_beat;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n)
      beat <= '0;
    else if (xfer)
      beat <= last_beat ? '0 : beat + BW'(1);
  end

  // Output mux straight off the stored slot; it only moves on a transfer,
  // so data holds for free while the consumer stalls.
  always_comb begin
    base        = 4'(int'(beat) * NLANE);
    bus.o_data  = '0;
    for (int m = 0; m < NLANE; m++)
      bus.o_data[m] = rd_frame[base + 4'(m)];
  end

  assign bus.o_sof = bus.o_valid && (beat == '0);
  assign bus.o_eof = bus.o_valid && last_beat;

endmodule

// File: tb/tb_fe_bf16_unscr.sv
// Scoreboard bench for fe_bf16_unscr: a NLANE=4 instance for the main scenarios
// and a NLANE=16 instance for one-frame-per-cycle streaming.
module tb_fe_bf16_unscr;
  import fe_pkg::*;

  logic       clk;
  logic       rst_async_n;
  logic       clr_ovf;
  logic       ovf4, ovf16;
  logic [1:0] level4, level16;

  int total;
  int bad;

  typedef struct {
    logic [3:0][1:0][11:0] d;
    logic                  sof;
    logic                  eof;
  } exp4_t;

  typedef struct {
    logic [15:0][1:0][11:0] d;
  } exp16_t;

  exp4_t  q4[$];
  exp16_t q16[$];

  fe_bf16_unscr_if #(.NBW(12), .NLANE(4))  bus4 ();
  fe_bf16_unscr_if #(.NBW(12), .NLANE(16)) bus16 ();

  fe_bf16_unscr #(.NBW(12), .NLANE(4)) dut4 (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .bus         (bus4),
    .i_clr_ovf   (clr_ovf),
    .o_ovf       (ovf4),
    .o_level     (level4)
  );

  fe_bf16_unscr #(.NBW(12), .NLANE(16)) dut16 (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .bus         (bus16),
    .i_clr_ovf   (clr_ovf),
    .o_ovf       (ovf16),
    .o_level     (level16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane p of a test frame: I = seed+p, Q = -(seed+p).
  function automatic logic [15:0][1:0][11:0] mk_frame(input int seed);
    logic [15:0][1:0][11:0] f;
    for (int p = 0; p < 16; p++) begin
      f[p][0] = 12'(seed + p);
      f[p][1] = 12'(-(seed + p));
    end
    return f;
  endfunction

  // Natural bin b was delivered on lane (b mod 4)*4 + (b div 4).
  task automatic push4(input int seed);
    exp4_t e;
    int    b, src;
    for (int t = 0; t < 4; t++) begin
      for (int m = 0; m < 4; m++) begin
        b   = t * 4 + m;
        src = (b % 4) * 4 + b / 4;
        e.d[m][0] = 12'(seed + src);
        e.d[m][1] = 12'(-(seed + src));
      end
      e.sof = (t == 0);
      e.eof = (t == 3);
      q4.push_back(e);
    end
  endtask

  task automatic push16(input int seed);
    exp16_t e;
    int     src;
    for (int b = 0; b < 16; b++) begin
      src = (b % 4) * 4 + b / 4;
      e.d[b][0] = 12'(seed + src);
      e.d[b][1] = 12'(-(seed + src));
    end
    q16.push_back(e);
  endtask

  task automatic test_reset();
    rst_async_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus4.o_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", bus4.o_valid);
    end
    total++;
    if ({bus4.o_sof, bus4.o_eof} !== 2'b00) begin
      bad++; $display("FAIL reset_sof_eof: got %b want 00", {bus4.o_sof, bus4.o_eof});
    end
    total++;
    if (ovf4 !== 1'b0) begin
      bad++; $display("FAIL reset_ovf: got %b want 0", ovf4);
    end
    total++;
    if (level4 !== 2'd0) begin
      bad++; $display("FAIL reset_level: got %0d want 0", level4);
    end
    total++;
    if ({bus16.o_valid, ovf16, level16} !== 4'b0) begin
      bad++; $display("FAIL reset_dut16: got %b want 0000", {bus16.o_valid, ovf16, level16});
    end
    rst_async_n = 1'b1;
    tick();
    total++;
    if (bus4.o_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset_valid: got %b want 0", bus4.o_valid);
    end
  endtask

  task automatic test_single();
    exp4_t e;
    int    nb;
    logic [11:0] exp_i0 [4];
    logic [11:0] exp_i1 [4];
    exp_i0 = '{12'd0, 12'd4, 12'd8, 12'd12};
    exp_i1 = '{12'd1, 12'd5, 12'd9, 12'd13};
    bus4.i_ready = 1'b1;
    bus4.i_data  = mk_frame(0);
    bus4.i_valid = 1'b1;
    push4(0);
    tick();
    bus4.i_valid = 1'b0;
    total++;
    if (bus4.o_valid !== 1'b1) begin
      bad++; $display("FAIL single_latency: got o_valid=%b want 1", bus4.o_valid);
    end
    nb = 0;
    for (int c = 0; c < 20 && q4.size() > 0; c++) begin
      if (bus4.o_valid && bus4.i_ready) begin
        e = q4.pop_front();
        total++;
        if (bus4.o_data !== e.d || bus4.o_sof !== e.sof || bus4.o_eof !== e.eof) begin
          bad++; $display("FAIL single_beat%0d: got %h sof=%b eof=%b want %h sof=%b eof=%b",
                          nb, bus4.o_data, bus4.o_sof, bus4.o_eof, e.d, e.sof, e.eof);
        end
        for (int m = 0; m < 4; m++) begin
          if (nb < 2) begin
            total++;
            if (bus4.o_data[m][0] !== ((nb == 0) ? exp_i0[m] : exp_i1[m])) begin
              bad++; $display("FAIL single_const_b%0d_l%0d: got %0d want %0d", nb, m,
                              bus4.o_data[m][0], (nb == 0) ? exp_i0[m] : exp_i1[m]);
            end
          end
        end
        nb++;
      end
      tick();
    end
    total++;
    if (q4.size() != 0 || bus4.o_valid !== 1'b0 || level4 !== 2'd0) begin
      bad++; $display("FAIL single_drain: got left=%0d valid=%b level=%0d want 0 0 0",
                      q4.size(), bus4.o_valid, level4);
      q4.delete();
    end
  endtask

  task automatic test_backpressure();
    exp4_t e;
    logic [3:0][1:0][11:0] held;
    logic  held_sof, held_eof, held_v;
    logic  pat [4];
    int    nxf;
    pat      = '{1'b1, 1'b0, 1'b0, 1'b1};
    held     = '0;
    held_sof = 1'b0;
    held_eof = 1'b0;
    held_v   = 1'b0;
    nxf      = 0;
    bus4.i_ready = 1'b0;
    bus4.i_data  = mk_frame(40);
    bus4.i_valid = 1'b1;
    push4(40);
    tick();
    bus4.i_valid = 1'b0;
    for (int c = 0; c < 40 && q4.size() > 0; c++) begin
      if (held_v) begin
        total++;
        if (bus4.o_data !== held || bus4.o_sof !== held_sof || bus4.o_eof !== held_eof) begin
          bad++; $display("FAIL bp_stable: got %h sof=%b eof=%b want %h sof=%b eof=%b",
                          bus4.o_data, bus4.o_sof, bus4.o_eof, held, held_sof, held_eof);
        end
      end
      bus4.i_ready = pat[c % 4];
      if (bus4.o_valid && bus4.i_ready) begin
        e = q4.pop_front();
        total++;
        if (bus4.o_data !== e.d || bus4.o_sof !== e.sof || bus4.o_eof !== e.eof) begin
          bad++; $display("FAIL bp_beat%0d: got %h want %h", nxf, bus4.o_data, e.d);
        end
        nxf++;
        held_v = 1'b0;
      end else if (bus4.o_valid) begin
        held     = bus4.o_data;
        held_sof = bus4.o_sof;
        held_eof = bus4.o_eof;
        held_v   = 1'b1;
      end
      tick();
    end
    bus4.i_ready = 1'b1;
    total++;
    if (nxf != 4 || bus4.o_valid !== 1'b0) begin
      bad++; $display("FAIL bp_count: got beats=%0d valid=%b want 4 0", nxf, bus4.o_valid);
      q4.delete();
    end
  endtask

  task automatic test_overflow();
    exp4_t e;
    bus4.i_ready = 1'b0;
    bus4.i_valid = 1'b1;
    bus4.i_data  = mk_frame(100); push4(100); tick();
    bus4.i_data  = mk_frame(200); push4(200); tick();
    bus4.i_data  = mk_frame(300);             tick();
    bus4.i_valid = 1'b0;
    tick();
    total++;
    if (level4 !== 2'd2 || ovf4 !== 1'b1) begin
      bad++; $display("FAIL ovf_set: got level=%0d ovf=%b want 2 1", level4, ovf4);
    end
    bus4.i_ready = 1'b1;
    for (int c = 0; c < 20 && q4.size() > 0; c++) begin
      if (bus4.o_valid) begin
        e = q4.pop_front();
        total++;
        if (bus4.o_data !== e.d || bus4.o_sof !== e.sof || bus4.o_eof !== e.eof) begin
          bad++; $display("FAIL ovf_drain: got %h want %h", bus4.o_data, e.d);
        end
      end
      tick();
    end
    total++;
    if (q4.size() != 0 || bus4.o_valid !== 1'b0 || ovf4 !== 1'b1) begin
      bad++; $display("FAIL ovf_after_drain: got left=%0d valid=%b ovf=%b want 0 0 1",
                      q4.size(), bus4.o_valid, ovf4);
      q4.delete();
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    total++;
    if (ovf4 !== 1'b0) begin
      bad++; $display("FAIL ovf_clear: got %b want 0", ovf4);
    end
    // A drop and a clear in the same cycle must leave the flag set.
    bus4.i_ready = 1'b0;
    bus4.i_valid = 1'b1;
    bus4.i_data  = mk_frame(400); push4(400); tick();
    bus4.i_data  = mk_frame(500); push4(500); tick();
    bus4.i_data  = mk_frame(600);
    clr_ovf      = 1'b1;
    tick();
    bus4.i_valid = 1'b0;
    clr_ovf      = 1'b0;
    total++;
    if (ovf4 !== 1'b1) begin
      bad++; $display("FAIL ovf_set_wins: got %b want 1", ovf4);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    bus4.i_ready = 1'b1;
    for (int c = 0; c < 20 && q4.size() > 0; c++) begin
      if (bus4.o_valid) begin
        e = q4.pop_front();
        total++;
        if (bus4.o_data !== e.d || bus4.o_sof !== e.sof || bus4.o_eof !== e.eof) begin
          bad++; $display("FAIL ovf_drain2: got %h want %h", bus4.o_data, e.d);
        end
      end
      tick();
    end
    total++;
    if (q4.size() != 0 || bus4.o_valid !== 1'b0 || ovf4 !== 1'b0) begin
      bad++; $display("FAIL ovf_end: got left=%0d valid=%b ovf=%b want 0 0 0",
                      q4.size(), bus4.o_valid, ovf4);
      q4.delete();
    end
  endtask

  task automatic test_simultaneous();
    exp4_t e;
    logic  sent, did;
    sent = 1'b0;
    bus4.i_ready = 1'b0;
    bus4.i_valid = 1'b1;
    bus4.i_data  = mk_frame(700); push4(700); tick();
    bus4.i_data  = mk_frame(800); push4(800); tick();
    bus4.i_valid = 1'b0;
    total++;
    if (level4 !== 2'd2) begin
      bad++; $display("FAIL simul_full: got level=%0d want 2", level4);
    end
    bus4.i_ready = 1'b1;
    for (int c = 0; c < 40 && q4.size() > 0; c++) begin
      did = 1'b0;
      if (bus4.o_valid) begin
        e = q4.pop_front();
        total++;
        if (bus4.o_data !== e.d || bus4.o_sof !== e.sof || bus4.o_eof !== e.eof) begin
          bad++; $display("FAIL simul_beat: got %h want %h", bus4.o_data, e.d);
        end
        if (bus4.o_eof && !sent) begin
          bus4.i_valid = 1'b1;
          bus4.i_data  = mk_frame(900);
          push4(900);
          sent = 1'b1;
          did  = 1'b1;
        end
      end
      tick();
      if (did) begin
        bus4.i_valid = 1'b0;
        total++;
        if (level4 !== 2'd2 || ovf4 !== 1'b0) begin
          bad++; $display("FAIL simul_accept: got level=%0d ovf=%b want 2 0", level4, ovf4);
        end
      end
    end
    total++;
    if (q4.size() != 0 || bus4.o_valid !== 1'b0) begin
      bad++; $display("FAIL simul_drain: got left=%0d valid=%b want 0 0", q4.size(), bus4.o_valid);
      q4.delete();
    end
  endtask

  task automatic test_nlane16();
    exp16_t e;
    bus16.i_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        bus16.i_valid = 1'b1;
        bus16.i_data  = mk_frame(1000 + k * 16);
        push16(1000 + k * 16);
      end else begin
        bus16.i_valid = 1'b0;
      end
      if (k > 0) begin
        total++;
        if (bus16.o_valid !== 1'b1 || q16.size() == 0) begin
          bad++; $display("FAIL n16_valid%0d: got %b want 1", k, bus16.o_valid);
        end else begin
          e = q16.pop_front();
          total++;
          if (bus16.o_data !== e.d || bus16.o_sof !== 1'b1 || bus16.o_eof !== 1'b1) begin
            bad++; $display("FAIL n16_frame%0d: got %h sof=%b eof=%b want %h sof=1 eof=1",
                            k - 1, bus16.o_data, bus16.o_sof, bus16.o_eof, e.d);
          end
        end
        total++;
        if (level16 > 2'd1) begin
          bad++; $display("FAIL n16_level: got %0d want <=1", level16);
        end
      end
      tick();
    end
    total++;
    if (bus16.o_valid !== 1'b0 || q16.size() != 0) begin
      bad++; $display("FAIL n16_end: got valid=%b left=%0d want 0 0", bus16.o_valid, q16.size());
      q16.delete();
    end
  endtask

  task automatic test_reset_mid();
    exp4_t e;
    bus4.i_ready = 1'b0;
    bus4.i_valid = 1'b1;
    bus4.i_data  = mk_frame(1100); push4(1100); tick();
    bus4.i_data  = mk_frame(1200); push4(1200); tick();
    bus4.i_valid = 1'b0;
    bus4.i_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      e = q4.pop_front();
      total++;
      if (bus4.o_data !== e.d || bus4.o_sof !== e.sof) begin
        bad++; $display("FAIL rstmid_beat%0d: got %h want %h", c, bus4.o_data, e.d);
      end
      tick();
    end
    e = q4[0];
    total++;
    if (bus4.o_valid !== 1'b1 || bus4.o_data !== e.d) begin
      bad++; $display("FAIL rstmid_beat2: got valid=%b %h want 1 %h", bus4.o_valid, bus4.o_data, e.d);
    end
    rst_async_n = 1'b0;
    #1;
    total++;
    if ({bus4.o_valid, bus4.o_sof, bus4.o_eof, ovf4, level4} !== 6'b0) begin
      bad++; $display("FAIL rstmid_async: got %b want 000000",
                      {bus4.o_valid, bus4.o_sof, bus4.o_eof, ovf4, level4});
    end
    q4.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_async_n = 1'b1;
    tick();
    total++;
    if (bus4.o_valid !== 1'b0 || level4 !== 2'd0) begin
      bad++; $display("FAIL rstmid_empty: got valid=%b level=%0d want 0 0", bus4.o_valid, level4);
    end
    bus4.i_valid = 1'b1;
    bus4.i_data  = mk_frame(1300);
    push4(1300);
    tick();
    bus4.i_valid = 1'b0;
    total++;
    if (bus4.o_sof !== 1'b1) begin
      bad++; $display("FAIL rstmid_sof: got %b want 1", bus4.o_sof);
    end
    for (int c = 0; c < 20 && q4.size() > 0; c++) begin
      if (bus4.o_valid) begin
        e = q4.pop_front();
        total++;
        if (bus4.o_data !== e.d || bus4.o_sof !== e.sof || bus4.o_eof !== e.eof) begin
          bad++; $display("FAIL rstmid_new: got %h want %h", bus4.o_data, e.d);
        end
      end
      tick();
    end
    total++;
    if (q4.size() != 0 || bus4.o_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_end: got left=%0d valid=%b want 0 0", q4.size(), bus4.o_valid);
      q4.delete();
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_async_n   = 1'b0;
    clr_ovf       = 1'b0;
    bus4.i_valid  = 1'b0;
    bus4.i_data   = '0;
    bus4.i_ready  = 1'b0;
    bus16.i_valid = 1'b0;
    bus16.i_data  = '0;
    bus16.i_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_simultaneous();
    test_nlane16();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
